ysyx_2022040010_icache_ctrl: RTL and testbench
==============================================

YSYX_2022040010_ICACHE_CTRL -- requirements
Module: ysyx_2022040010_icache_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 64, meaning the number of sets per way; the index is 6 bits.
REQ-002 SHALL have parameter TAG_W, default `TAG_WIDTH (55), meaning the tag width, equal to 64-6-3.
REQ-003 SHALL have one clock and an asynchronous, active-high reset. Ports are listed in REQ-004 to REQ-019.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sram_e, input, 1: fetch request valid.
REQ-007 SHALL have port sram_addr, input, 64: fetch address, split as {tag, index[5:0], offset[2:0]}.
REQ-008 SHALL have port cache, input, 1: 1 = address is cacheable.
REQ-009 SHALL have port fence_i, input, 1: single-cycle pulse that invalidates all lines.
REQ-010 SHALL have port hit, output, `HIT_WIDTH (2): one-hot way-hit to the data array.
REQ-011 SHALL have port lru, output, 1: victim way for the set at the current index.
REQ-012 SHALL have port refresh, output, 1: single-cycle data-array write strobe.
REQ-013 SHALL have port cacheline_new, output, 64: refill line to the data array.
REQ-014 SHALL have port stall_o, output, 1: fetch must hold sram_addr and sram_e.
REQ-015 SHALL have port uc_over_o, output, 1: uncached read data is valid this cycle.
REQ-016 SHALL have port uc_rdata_o, output, 64: uncached instruction, {32'b0, word selected by offset[2]}.
REQ-017 SHALL have AXI read-address ports: ar_valid (output, 1), ar_ready (input, 1), ar_addr (output, 64).
REQ-018 SHALL have AXI read-data ports: r_valid (input, 1), r_ready (output, 1), r_data (input, 64). Each transaction is a single beat (len 0, size 8 B).
REQ-019 SHALL have no other ports.

Function
REQ-020 Storage SHALL be: tag[2][64], valid[2][64], lru_bit[64].
- lru_bit = 0 means way0 is the victim.
REQ-021 Hit SHALL be computed combinationally in IDLE.
- hit[w] = sram_e & cache & valid[w][index] & (tag[w][index] == tag).
- hit is forced to 0 in every other state.
REQ-022 On a hit cycle:
- lru_bit[index] SHALL be set to the non-hit way at the next edge.
- stall_o SHALL be 0.
REQ-023 FSM states SHALL be IDLE, MISS_AR, MISS_R, REFILL, UC_AR, UC_R.
REQ-024 In IDLE:
- sram_e & cache & ~|hit SHALL go to MISS_AR.
- sram_e & ~cache SHALL go to UC_AR.
- stall_o = sram_e & ~|hit.
REQ-025 In MISS_AR and UC_AR:
- ar_valid = 1.
- ar_addr = {sram_addr[63:3], 3'b000}.
- ar_addr is held stable until ar_valid & ar_ready.
- The handshake advances to MISS_R or UC_R respectively.
REQ-026 In MISS_R and UC_R:
- r_ready = 1.
- r_valid latches r_data into an internal line buffer.
- MISS_R advances to REFILL; UC_R returns to IDLE.
REQ-027 UC_R -> IDLE transition:
- uc_over_o SHALL pulse for exactly one cycle, on the cycle after the r handshake.
- uc_rdata_o is valid during that pulse.
- stall_o is 0 during that pulse.
REQ-028 In REFILL, for one cycle:
- refresh = 1.
- lru = lru_bit[index].
- cacheline_new = line buffer.
- At the edge: tag[lru][index] <= tag, valid[lru][index] <= 1, lru_bit[index] <= ~lru_bit[index].
- Next state is IDLE, where the re-lookup hits.
REQ-029 Outside REFILL, outputs SHALL take these values:
- refresh = 0.
- cacheline_new = 0.
- lru = lru_bit[index] (combinational).
REQ-030 stall_o SHALL be 1 in every state except as given in REQ-022, REQ-024 and REQ-027.
REQ-031 fence_i in IDLE SHALL clear all valid and lru_bit at the next edge.
- If fence_i coincides with a hit, fence_i takes priority: hit is forced to 0 and the request proceeds as a miss.
REQ-032 fence_i in any other state SHALL be latched and applied on the first IDLE cycle.
REQ-033 Once ar_valid is asserted, it SHALL NOT be withdrawn before ar_ready.
REQ-034 A change of sram_e or sram_addr while stall_o = 1 is a fetch protocol error.
- Behaviour is undefined; no recovery is required.

Reset
REQ-035 On rst = 1, asynchronously:
- state = IDLE.
- All valid = 0 and all lru_bit = 0.
- Line buffer = 0; fence latch = 0.
- ar_valid = 0, r_ready = 0, refresh = 0, uc_over_o = 0, hit = 0.
REQ-036 Tag contents need not be reset.
REQ-037 Reset asserted mid-transaction SHALL abandon the outstanding AXI read; no handshake is resumed after deassertion.

Structure
REQ-038 The shared defines package SHALL hold `TAG_WIDTH, `HIT_WIDTH and the state encodings.
REQ-039 The tag/valid store SHALL be one sub-module, ysyx_2022040010_icache_tag.
- Two ways; combinational read by index.
- Write by way and index.
- Bulk invalidate.
REQ-040 The FSM and LRU logic SHALL reside in the top module.

Verification
REQ-041 Cold miss: after reset, sram_e = 1, cache = 1, addr 0x8000_0000.
- Required: ar_addr = 0x8000_0000; r_data = 0x1111_2222_3333_4444.
- Required: refresh pulse with lru = 0; then hit = 2'b01 with stall_o = 0.
- Addr 0x8000_0004 then hits way0 without any AXI traffic.
REQ-042 Conflict: fill 0x8000_0000, then 0x8000_0200 (same index 0).
- Required: second refill uses lru = 1.
- Third address 0x8000_0400 evicts way0; 0x8000_0200 still hits way1.
REQ-043 Uncached: cache = 0, addr 0xA000_0004, r_data = 0xDEAD_BEEF_0000_0000.
- Required: one uc_over_o pulse with uc_rdata_o = 0xDEAD_BEEF.
- Required: refresh never asserted.
REQ-044 Backpressure: ar_ready held 0 for 5 cycles, r_valid delayed 3 cycles.
- Required: ar_valid and ar_addr stable throughout; stall_o = 1 throughout.
REQ-045 fence_i:
- fence_i during MISS_R: the refill completes, and the next IDLE cycle invalidates, so the re-lookup misses again.
- fence_i in IDLE coinciding with a hit: the access misses.
REQ-046 Reset asserted during MISS_R: ar_valid = 0 and r_ready = 0 immediately; the next access to the same address misses.

Source files
------------

// File: rtl/ysyx_2022040010_icache_ctrl_pkg.sv
// Shared widths, state encoding and address helpers for the instruction cache controller.
package ysyx_2022040010_icache_ctrl_pkg;

    localparam int TAG_WIDTH = 55;
    localparam int HIT_WIDTH = 2;
    localparam int IDX_W     = 6;
    localparam int OFF_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MISS_AR = 3'd1,
        S_MISS_R  = 3'd2,
        S_REFILL  = 3'd3,
        S_UC_AR   = 3'd4,
        S_UC_R    = 3'd5
    } icache_state_e;

    // Bus reads are always one aligned 8-byte beat.
    function automatic logic [63:0] line_addr(input logic [63:0] a);
        return a & 64'hFFFF_FFFF_FFFF_FFF8;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_icache_tag.sv
// Two-way tag/valid store: combinational read by index, write by way+index, bulk invalidate.
module ysyx_2022040010_icache_tag
    import ysyx_2022040010_icache_ctrl_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      index,
    input  logic                  we,
    input  logic                  way,
    input  logic [TAG_W-1:0]      wtag,
    input  logic                  inv,
    output logic [1:0][TAG_W-1:0] rtag,
    output logic [1:0]            rvalid
);

    logic [TAG_W-1:0] tag_mem [2][SETS];
    logic [SETS-1:0]  valid_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
        end else if (inv) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
        end else if (we) begin
            valid_q[way][index] <= 1'b1;
        end
    end

    // Tags carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) tag_mem[way][index] <= wtag;
    end

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            rtag[w]   = tag_mem[w][index];
            rvalid[w] = valid_q[w][index];
        end
    end

endmodule

// File: rtl/ysyx_2022040010_icache_ctrl.sv
// Instruction cache controller: 2-way lookup, LRU victim choice, single-beat AXI refill
// and uncached fetch. AXI channels: a beat transfers on the edge where valid & ready.
module ysyx_2022040010_icache_ctrl
    import ysyx_2022040010_icache_ctrl_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sram_e,
    input  logic [63:0]          sram_addr,
    input  logic                 cache,
    input  logic                 fence_i,
    output logic [HIT_WIDTH-1:0] hit,
    output logic                 lru,
    output logic                 refresh,
    output logic [63:0]          cacheline_new,
    output logic                 stall_o,
    output logic                 uc_over_o,
    output logic [63:0]          uc_rdata_o,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [63:0]          ar_addr,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [63:0]          r_data
);

    icache_state_e        state, state_nxt;
    logic [SETS-1:0]      lru_bit;
    logic [63:0]          line_q;
    logic [63:0]          ar_addr_q;
    logic                 fence_pend;
    logic                 uc_over_q;
    logic                 is_idle;
    logic                 fence_act;
    logic [IDX_W-1:0]     index;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0][TAG_W-1:0] rtag;
    logic [1:0]           rvalid;

    assign index     = sram_addr[OFF_W +: IDX_W];
    assign req_tag   = sram_addr[OFF_W+IDX_W +: TAG_W];
    assign is_idle   = (state == S_IDLE);
    // A fence raised while busy is held and takes effect on the first idle cycle.
    assign fence_act = is_idle & (fence_i | fence_pend);

    ysyx_2022040010_icache_tag #(.SETS(SETS), .TAG_W(TAG_W)) u_tag (
        .clk    (clk),
        .rst    (rst),
        .index  (index),
        .we     (refresh),
        .way    (lru),
        .wtag   (req_tag),
        .inv    (fence_act),
        .rtag   (rtag),
        .rvalid (rvalid)
    );

    always_comb begin
        for (int w = 0; w < HIT_WIDTH; w++) begin
            hit[w] = is_idle & ~fence_act & sram_e & cache & rvalid[w] & (rtag[w] == req_tag);
        end
    end

    assign lru        = lru_bit[index];
    assign ar_addr    = ar_addr_q;
    assign uc_over_o  = uc_over_q;
    assign uc_rdata_o = {32'b0, sram_addr[2] ? line_q[63:32] : line_q[31:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        stall_o       = 1'b1;
        ar_valid      = 1'b0;
        r_ready       = 1'b0;
        refresh       = 1'b0;
        cacheline_new = '0;
        unique case (state)
            S_IDLE: begin
                // The cycle delivering uncached data releases the fetch before any new lookup.
                stall_o = ~uc_over_q & sram_e & ~|hit;
                if (!uc_over_q) begin
                    if (sram_e & cache & ~|hit) state_nxt = S_MISS_AR;
                    else if (sram_e & ~cache)   state_nxt = S_UC_AR;
                end
            end
            S_MISS_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = S_MISS_R;
            end
            S_UC_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = S_UC_R;
            end
            S_MISS_R: begin
                r_ready = 1'b1;
                if (r_valid) state_nxt = S_REFILL;
            end
            S_UC_R: begin
                r_ready = 1'b1;
                if (r_valid) state_nxt = S_IDLE;
            end
            S_REFILL: begin
                refresh       = 1'b1;
                cacheline_new = line_q;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_bit    <= '0;
            line_q     <= '0;
            ar_addr_q  <= '0;
            fence_pend <= 1'b0;
            uc_over_q  <= 1'b0;
        end else begin
            uc_over_q <= (state == S_UC_R) & r_valid;
            if (is_idle)         ar_addr_q <= line_addr(sram_addr);
            if (r_ready & r_valid) line_q  <= r_data;
            if (is_idle)         fence_pend <= 1'b0;
            else if (fence_i)    fence_pend <= 1'b1;
            // Point the victim at the way that was not just used.
            if (fence_act)       lru_bit        <= '0;
            else if (|hit)       lru_bit[index] <= hit[0];
            else if (refresh)    lru_bit[index] <= ~lru_bit[index];
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_icache_ctrl.sv
// Bench for the icache controller: AXI slave driven from tasks, scoreboard of per-fetch observations.
module tb_ysyx_2022040010_icache_ctrl;

    localparam int NF = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_e = 1'b0;
    logic [63:0] sram_addr = '0;
    logic        cache = 1'b0;
    logic        fence_i = 1'b0;
    logic [1:0]  hit;
    logic        lru;
    logic        refresh;
    logic [63:0] cacheline_new;
    logic        stall_o;
    logic        uc_over_o;
    logic [63:0] uc_rdata_o;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [63:0] ar_addr;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [63:0] r_data = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];
    string names [NF] = '{"ar_addr", "ar_cnt", "refresh_cnt", "refill_lru", "refill_line", "hit",
                          "uc_cnt", "uc_rdata", "stall_cycles", "ar_stable", "uc_after"};

    ysyx_2022040010_icache_ctrl dut (
        .clk(clk), .rst(rst), .sram_e(sram_e), .sram_addr(sram_addr), .cache(cache),
        .fence_i(fence_i), .hit(hit), .lru(lru), .refresh(refresh), .cacheline_new(cacheline_new),
        .stall_o(stall_o), .uc_over_o(uc_over_o), .uc_rdata_o(uc_rdata_o), .ar_valid(ar_valid),
        .ar_ready(ar_ready), .ar_addr(ar_addr), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
    );

    always #5 clk = ~clk;

    task automatic expect_fetch(input logic [63:0] e_ar, input int e_arc, input int e_refc,
                                input logic e_lru, input logic [63:0] e_line, input logic [1:0] e_hit,
                                input int e_ucc, input logic [63:0] e_uc, input int e_cyc);
        exp_q.push_back(e_ar);
        exp_q.push_back(64'(e_arc));
        exp_q.push_back(64'(e_refc));
        exp_q.push_back({63'd0, e_lru});
        exp_q.push_back(e_line);
        exp_q.push_back({62'd0, e_hit});
        exp_q.push_back(64'(e_ucc));
        exp_q.push_back(e_uc);
        exp_q.push_back(64'(e_cyc));
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd0);
    endtask

    // fmode: 0 none, 1 fence_i with the request, 2 fence_i during the first read-data cycle.
    task automatic fetch(input logic [63:0] addr, input logic c, input logic [63:0] rdata,
                         input int aw, input int rw, input int fmode);
        logic [63:0] o [NF];
        logic [63:0] first_ar;
        int ac, rc;
        bit pend, fenced, done;
        for (int i = 0; i < NF; i++) o[i] = '0;
        o[9] = 64'd1;
        first_ar = '0; ac = 0; rc = 0; pend = 0; fenced = 0; done = 0;
        sram_e = 1'b1; sram_addr = addr; cache = c; fence_i = (fmode == 1);
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (!stall_o) begin
                done = 1;
                o[5] = {62'd0, hit};
                if (uc_over_o) begin o[6] += 1; o[7] = uc_rdata_o; end
            end else begin
                o[8] += 1;
                if (pend && (ar_valid !== 1'b1 || ar_addr !== first_ar)) o[9] = '0;
                if (ar_valid) begin
                    if (!pend) begin pend = 1; first_ar = ar_addr; o[0] = ar_addr; end
                    if (ac == aw) begin ar_ready = 1'b1; o[1] += 1; pend = 0; ac = 0; end
                    else ac++;
                end
                if (r_ready) begin
                    if (fmode == 2 && !fenced) begin fence_i = 1'b1; fenced = 1; end
                    if (rc == rw) begin r_valid = 1'b1; r_data = rdata; rc = 0; end
                    else rc++;
                end
                if (refresh) begin o[2] += 1; o[3] = {63'd0, lru}; o[4] = cacheline_new; end
                if (uc_over_o) o[6] += 1;
                @(posedge clk); #1;
                ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; fence_i = 1'b0;
            end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL fetch_timeout addr %h: stall_o still %b after 200 cycles, required 0", addr, stall_o);
        end
        @(posedge clk); #1;
        sram_e = 1'b0; fence_i = 1'b0;
        #1;
        o[10] = {63'd0, uc_over_o};
        for (int i = 0; i < NF; i++) act_q.push_back(o[i]);
    endtask

    task automatic drain(input string tname);
        logic [63:0] a, e;
        int fld = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s %s: got %h, required %h", tname, names[fld], a, e);
            end
            fld = (fld + 1) % NF;
        end
        act_q.delete();
    endtask

    task automatic test_reset();
        logic [63:0] got [9];
        @(posedge clk); #1;
        @(posedge clk); #2;
        got = '{{63'd0, ar_valid}, {63'd0, r_ready}, {63'd0, refresh}, {63'd0, uc_over_o},
                {62'd0, hit}, {63'd0, stall_o}, cacheline_new, {63'd0, lru}, uc_rdata_o};
        for (int i = 0; i < 9; i++) exp_q.push_back(64'd0);
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (got[i] !== exp_q.pop_front()) begin
                miscompares++;
                $display("FAIL reset output %0d: got %h, required 0", i, got[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        expect_fetch(64'h8000_0000, 1, 1, 1'b0, 64'h1111_2222_3333_4444, 2'b01, 0, 64'd0, 4);
        fetch(64'h8000_0000, 1'b1, 64'h1111_2222_3333_4444, 0, 0, 0);
        expect_fetch(64'd0, 0, 0, 1'b0, 64'd0, 2'b01, 0, 64'd0, 0);
        fetch(64'h8000_0004, 1'b1, 64'h0, 0, 0, 0);
        drain("cold_miss");
    endtask

    task automatic test_conflict();
        expect_fetch(64'h8000_0200, 1, 1, 1'b1, 64'hAAAA_0000_0000_0200, 2'b10, 0, 64'd0, 4);
        fetch(64'h8000_0200, 1'b1, 64'hAAAA_0000_0000_0200, 0, 0, 0);
        expect_fetch(64'h8000_0400, 1, 1, 1'b0, 64'hBBBB_0000_0000_0400, 2'b01, 0, 64'd0, 4);
        fetch(64'h8000_0400, 1'b1, 64'hBBBB_0000_0000_0400, 0, 0, 0);
        expect_fetch(64'd0, 0, 0, 1'b0, 64'd0, 2'b10, 0, 64'd0, 0);
        fetch(64'h8000_0200, 1'b1, 64'h0, 0, 0, 0);
        drain("conflict");
    endtask

    task automatic test_uncached();
        expect_fetch(64'hA000_0000, 1, 0, 1'b0, 64'd0, 2'b00, 1, 64'h0000_0000_DEAD_BEEF, 3);
        fetch(64'hA000_0004, 1'b0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0);
        expect_fetch(64'hA000_0000, 1, 0, 1'b0, 64'd0, 2'b00, 1, 64'h0000_0000_0000_1234, 3);
        fetch(64'hA000_0000, 1'b0, 64'h5678_9ABC_0000_1234, 0, 0, 0);
        drain("uncached");
    endtask

    task automatic test_backpressure();
        expect_fetch(64'h8000_0108, 1, 1, 1'b0, 64'hC0DE_C0DE_0108_0108, 2'b01, 0, 64'd0, 12);
        fetch(64'h8000_010C, 1'b1, 64'hC0DE_C0DE_0108_0108, 5, 3, 0);
        expect_fetch(64'h8000_0040, 1, 1, 1'b0, 64'h0000_0040_0000_0040, 2'b01, 0, 64'd0,
                     4 + 2 + 7);
        fetch(64'h8000_0040, 1'b1, 64'h0000_0040_0000_0040, 2, 7, 0);
        drain("backpressure");
    endtask

    task automatic test_fence();
        expect_fetch(64'h8000_0208, 2, 2, 1'b0, 64'hFE0C_E000_0000_0208, 2'b01, 0, 64'd0, 8);
        fetch(64'h8000_0208, 1'b1, 64'hFE0C_E000_0000_0208, 0, 0, 2);
        expect_fetch(64'd0, 0, 0, 1'b0, 64'd0, 2'b01, 0, 64'd0, 0);
        fetch(64'h8000_0208, 1'b1, 64'h0, 0, 0, 0);
        expect_fetch(64'h8000_0208, 1, 1, 1'b0, 64'h1234_0000_0000_0208, 2'b01, 0, 64'd0, 4);
        fetch(64'h8000_0208, 1'b1, 64'h1234_0000_0000_0208, 0, 0, 1);
        expect_fetch(64'h8000_0400, 1, 1, 1'b0, 64'h5555_0000_0000_0400, 2'b01, 0, 64'd0, 4);
        fetch(64'h8000_0400, 1'b1, 64'h5555_0000_0000_0400, 0, 0, 0);
        drain("fence");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        sram_e = 1'b1; sram_addr = 64'h8000_0300; cache = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            #1;
            if (r_ready) seen = 1;
            else begin
                if (ar_valid) ar_ready = 1'b1;
                @(posedge clk); #1;
                ar_ready = 1'b0;
            end
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (!seen || ar_valid !== 1'b0 || r_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid axi: reached_r=%0d ar_valid=%b r_ready=%b, required 1/0/0", seen, ar_valid, r_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; sram_e = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (ar_valid !== 1'b0 || r_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid resume: ar_valid=%b r_ready=%b, required 0/0", ar_valid, r_ready);
        end
        expect_fetch(64'h8000_0300, 1, 1, 1'b0, 64'h0300_0300_0300_0300, 2'b01, 0, 64'd0, 4);
        fetch(64'h8000_0300, 1'b1, 64'h0300_0300_0300_0300, 0, 0, 0);
        expect_fetch(64'h8000_0000, 1, 1, 1'b0, 64'h7777_0000_0000_0000, 2'b01, 0, 64'd0, 4);
        fetch(64'h8000_0000, 1'b1, 64'h7777_0000_0000_0000, 0, 0, 0);
        drain("reset_mid");
    endtask

    task automatic test_random_hits();
        logic [63:0] a;
        for (int n = 0; n < 6; n++) begin
            a = 64'h8000_0300 | 64'($urandom_range(0, 7));
            expect_fetch(64'd0, 0, 0, 1'b0, 64'd0, 2'b01, 0, 64'd0, 0);
            fetch(a, 1'b1, 64'h0, 0, 0, 0);
        end
        drain("random_hits");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_uncached();
        test_backpressure();
        test_fence();
        test_reset_mid();
        test_random_hits();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
